// File: rtl/input_conditioner.sv
// Switch/button front end for the CPU core: synchronises the raw inputs, debounces
// the enter button and freezes the switch value before ready_in is raised.
module input_conditioner #(
  parameter int BUS_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] sw_raw,
  input  logic                 btn_raw,
  output logic [BUS_WIDTH-1:0] in_port,
  output logic                 ready_in,
  output logic                 busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LEAD_LAST = CW'(1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    LEAD         = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          latch;

  logic [SYNC_STAGES-1:0][BUS_WIDTH-1:0] sw_pipe;
  logic [SYNC_STAGES-1:0]                btn_pipe;
  logic [BUS_WIDTH-1:0]                  sw_sync;
  logic                                  btn_sync;

  assign sw_sync  = sw_pipe[SYNC_STAGES-1];
  assign btn_sync = btn_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_pipe  <= '0;
      btn_pipe <= '0;
    end else begin
      sw_pipe  <= {sw_pipe[SYNC_STAGES-2:0], sw_raw};
      btn_pipe <= {btn_pipe[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // cnt is shared: debounce run length in the WAIT states, cycle count in LEAD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LEAD;
          cnt_nxt   = '0;
          latch     = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      LEAD: begin
        if (cnt == LEAD_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      in_port  <= '0;
      ready_in <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ready_in <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
      busy     <= (state_nxt != IDLE);
      if (latch) in_port <= sw_sync;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a run-length
// model of the debounce rules.
module tb_input_conditioner;

  localparam int BW   = 8;
  localparam int DEB  = 16;
  localparam int SYNC = 2;

  logic          clk;
  logic          reset;
  logic [BW-1:0] sw_raw;
  logic          btn_raw;
  logic [BW-1:0] in_port;
  logic          ready_in;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] exp_q[$];

  input_conditioner #(
    .BUS_WIDTH(BW),
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .btn_raw(btn_raw),
    .in_port(in_port),
    .ready_in(ready_in),
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw inputs delayed SYNC edges, then the button is judged
  // by the length of the current run of samples opposite to the accepted level.
  logic [BW-1:0] sw_hist [SYNC];
  logic          btn_hist[SYNC];
  int            m_run;
  int            m_lead;
  bit            m_level;
  logic [BW-1:0] exp_in_port;
  logic          exp_ready;
  logic          exp_busy;

  always @(posedge clk) begin
    logic          s;
    logic [BW-1:0] sws;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) begin
        sw_hist[i]  = '0;
        btn_hist[i] = 1'b0;
      end
      m_run = 0; m_lead = 0; m_level = 0;
      exp_in_port = '0; exp_ready = 1'b0; exp_busy = 1'b0;
    end else begin
      s   = btn_hist[SYNC-1];
      sws = sw_hist[SYNC-1];
      if (m_lead > 0) begin
        m_lead--;
        if (m_lead == 0) m_level = 1;
      end else if (s != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_run = 0;
          if (!m_level) begin
            exp_in_port = sws;
            m_lead = 2;
          end else begin
            m_level = 0;
          end
        end
      end else begin
        m_run = 0;
      end
      exp_ready = m_level;
      exp_busy  = m_level || (m_lead > 0) || (m_run > 0);
      for (int i = SYNC - 1; i > 0; i--) begin
        sw_hist[i]  = sw_hist[i-1];
        btn_hist[i] = btn_hist[i-1];
      end
      sw_hist[0]  = sw_raw;
      btn_hist[0] = btn_raw;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sw_raw = 8'hA5; btn_raw = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if (in_port !== 8'h00 || ready_in !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: got in_port=%h ready=%b busy=%b want 00 0 0", in_port, ready_in, busy);
      end
    end
    reset = 1'b0;
    for (int j = 0; j < 22; j++) begin
      tick();  // now just after edge k+j
      total++;
      if (j == 16 && in_port !== 8'h00) begin
        bad++; $display("FAIL reset_redebounce_early: got %h want 00", in_port);
      end
      if (j == 17 && in_port !== 8'hA5) begin
        bad++; $display("FAIL reset_redebounce_latch: got %h want a5", in_port);
      end
      if (in_port !== exp_in_port || ready_in !== exp_ready || busy !== exp_busy) begin
        bad++;
        $display("FAIL reset_model j=%0d: got %h %b %b want %h %b %b", j, in_port, ready_in, busy, exp_in_port, exp_ready, exp_busy);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    btn_raw = 1'b0; sw_raw = 8'h3C;
    tick();
    btn_raw = 1'b1;
    for (int j = 0; j < 22; j++) begin
      tick();
      total++;
      if ((j == 1 && busy !== 1'b0) || (j == 2 && busy !== 1'b1)) begin
        bad++; $display("FAIL latency_busy j=%0d: got %b", j, busy);
      end
      if ((j == 16 && in_port !== 8'h00) || (j == 17 && in_port !== 8'h3C)) begin
        bad++; $display("FAIL latency_in_port j=%0d: got %h", j, in_port);
      end
      if ((j == 18 && ready_in !== 1'b0) || (j == 19 && ready_in !== 1'b1)) begin
        bad++; $display("FAIL latency_ready j=%0d: got %b", j, ready_in);
      end
      if (in_port !== exp_in_port || ready_in !== exp_ready || busy !== exp_busy) begin
        bad++;
        $display("FAIL latency_model j=%0d: got %h %b %b want %h %b %b", j, in_port, ready_in, busy, exp_in_port, exp_ready, exp_busy);
      end
    end
  endtask

  task automatic test_press_glitch();
    do_reset();
    sw_raw = 8'h77; btn_raw = 1'b1;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (j == 9) btn_raw = 1'b0;
      total++;
      if (ready_in !== 1'b0 || in_port !== 8'h00) begin
        bad++; $display("FAIL press_glitch j=%0d: got ready=%b in_port=%h want 0 00", j, ready_in, in_port);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL press_glitch_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_release_glitch();
    do_reset();
    sw_raw = 8'h3C; btn_raw = 1'b1;
    repeat (22) tick();
    btn_raw = 1'b0;
    for (int j = 0; j < 15; j++) begin
      tick();
      if (j == 4) btn_raw = 1'b1;
      total++;
      if (ready_in !== 1'b1) begin
        bad++; $display("FAIL release_glitch_hold j=%0d: got %b want 1", j, ready_in);
      end
    end
    btn_raw = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();  // just after edge m+j
      total++;
      if ((j == 16 && ready_in !== 1'b1) || (j == 17 && ready_in !== 1'b0)) begin
        bad++; $display("FAIL release_fall j=%0d: got %b", j, ready_in);
      end
      if (in_port !== exp_in_port || ready_in !== exp_ready || busy !== exp_busy) begin
        bad++;
        $display("FAIL release_model j=%0d: got %h %b %b want %h %b %b", j, in_port, ready_in, busy, exp_in_port, exp_ready, exp_busy);
      end
    end
  endtask

  task automatic test_data_freeze();
    do_reset();
    sw_raw = 8'h3C; btn_raw = 1'b1;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (j >= 17) sw_raw = (j % 2 == 1) ? 8'hFF : 8'h3C;
      total++;
      if (j >= 17 && in_port !== 8'h3C) begin
        bad++; $display("FAIL freeze_held j=%0d: got %h want 3c", j, in_port);
      end
    end
    sw_raw = 8'hFF; btn_raw = 1'b0;
    repeat (20) tick();
    total++;
    if (in_port !== 8'h3C) begin
      bad++; $display("FAIL freeze_after_release: got %h want 3c", in_port);
    end
    btn_raw = 1'b1;
    repeat (22) tick();
    total++;
    if (in_port !== 8'hFF) begin
      bad++; $display("FAIL freeze_next_press: got %h want ff", in_port);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] cur;
    logic          prev_ready;
    int            pulses;
    do_reset();
    exp_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    prev_ready = 1'b0; pulses = 0; cur = '0;
    for (int p = 0; p < 2; p++) begin
      sw_raw = BW'(p + 1);
      for (int phase = 0; phase < 2; phase++) begin
        btn_raw = (phase == 0);
        for (int j = 0; j < 20; j++) begin
          tick();
          if (ready_in === 1'b1 && prev_ready === 1'b0) begin
            pulses++;
            if (exp_q.size() > 0) cur = exp_q.pop_front();
          end
          if (ready_in === 1'b1) begin
            total++;
            if (in_port !== cur) begin
              bad++; $display("FAIL b2b_data pulse=%0d: got %h want %h", pulses, in_port, cur);
            end
          end
          prev_ready = ready_in;
        end
      end
    end
    total++;
    if (pulses != 2 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_pulses: got %0d pulses want 2", pulses);
    end
  endtask

  task automatic test_random();
    int run_left;
    do_reset();
    run_left = 0;
    for (int j = 0; j < 1500; j++) begin
      if (run_left == 0) begin
        btn_raw  = ~btn_raw;
        run_left = $urandom_range(1, 24);
      end
      run_left--;
      if ($urandom_range(0, 3) == 0) sw_raw = BW'($urandom);
      reset = ($urandom_range(0, 249) == 0);
      tick();
      total++;
      if (in_port !== exp_in_port || ready_in !== exp_ready || busy !== exp_busy) begin
        bad++;
        $display("FAIL random_model j=%0d: got %h %b %b want %h %b %b", j, in_port, ready_in, busy, exp_in_port, exp_ready, exp_busy);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sw_raw = '0; btn_raw = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_press_glitch();
    test_release_glitch();
    test_data_freeze();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage directly upstream of the CPU core.
- Takes the raw switch bank and the raw "enter" push-button from the board. Synchronises both to clk and debounces the button.
- Drives the core's in_port and ready_in. in_port is frozen before ready_in rises, so the core's wait-for-ready and wait-for-pattern instructions always capture clean, stable data.

Parameters:
- BUS_WIDTH, 8, width of switch bank and in_port.
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a button press or release; legal range 2..65535.
- SYNC_STAGES, 2, synchroniser flop depth on every raw input; legal range 2..4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- sw_raw  input  BUS_WIDTH  asynchronous switch bank.
- btn_raw  input  1  asynchronous push-button, 1 = pressed.
- in_port  output  BUS_WIDTH  latched switch value, to core in_port.
- ready_in  output  1  debounced button level, to core ready_in.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Synchroniser:
  - Every bit of sw_raw and btn_raw passes through SYNC_STAGES flops.
  - The last stage gives sw_sync and btn_sync.
  - All synchroniser flops clear to 0 on reset.
- Debounce counter:
  - Width clog2(DEBOUNCE_CYCLES)+1, unsigned, no wrap.
  - Saturation is never reached because every comparison exits at DEBOUNCE_CYCLES-1.
- FSM states: IDLE, PRESS_WAIT, LEAD, HELD, RELEASE_WAIT. Reset state is IDLE.
- IDLE:
  - ready_in=0.
  - btn_sync=1 -> PRESS_WAIT, cnt=1.
- PRESS_WAIT:
  - btn_sync=0 -> IDLE, cnt=0 (glitch rejected).
  - btn_sync=1 and cnt==DEBOUNCE_CYCLES-1 -> LEAD. On the same edge: in_port<=sw_sync, cnt=0.
  - Otherwise cnt++.
- LEAD:
  - Lasts exactly 2 cycles unconditionally, then -> HELD. btn_sync is ignored.
  - ready_in stays 0, so the core's two-stage switch pipeline is filled with the frozen value before the ready edge.
- HELD:
  - ready_in=1.
  - btn_sync=0 -> RELEASE_WAIT, cnt=1.
- RELEASE_WAIT:
  - ready_in=1.
  - btn_sync=1 -> HELD, cnt=0.
  - btn_sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise cnt++.
- Output registers:
  - ready_in and busy are registered, decoded from the next state.
  - in_port changes only on the PRESS_WAIT->LEAD edge and is constant through LEAD, HELD and RELEASE_WAIT.
  - Switch changes outside that edge are never visible on in_port.
- Latency: with btn_raw first sampled high at edge k and held high:
  - in_port updates after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - ready_in rises after edge k+SYNC_STAGES+DEBOUNCE_CYCLES+1. Defaults: k+17 and k+19.
  - With btn_raw first sampled low at edge m and held low, ready_in falls after edge m+SYNC_STAGES+DEBOUNCE_CYCLES-1 (default m+17).
- Reset outputs: in_port=0, ready_in=0, busy=0, cnt=0.
- Reset mid-operation, in any state: on the next edge the block is in IDLE with all outputs 0. A button held through reset must be re-debounced in full after reset deasserts.
- Minimum press: a press needs DEBOUNCE_CYCLES consecutive 1 samples of btn_sync; a release needs DEBOUNCE_CYCLES consecutive 0 samples. Any opposite sample restarts the count.
- Simultaneous switch change and debounce completion: in_port takes the sw_sync value present on the completing edge.

Test Plan:
- Reset with btn_raw=1 and sw_raw=8'hA5 -> in_port=0, ready_in=0, busy=0 during reset. After release, press debounce restarts and in_port=8'hA5 appears after edge k+17, with k the first edge after reset deassert.
- sw_raw=8'h3C, btn_raw high at edge 10, held -> in_port=8'h3C after edge 27, ready_in=1 after edge 29, busy=1 from edge 12.
- Press glitch: btn_raw high for 10 cycles, then low -> ready_in never asserts, in_port unchanged, FSM returns to IDLE (busy=0).
- Release glitch: in HELD, btn_raw low for 5 cycles then high -> ready_in stays 1 throughout. A subsequent low held 20 cycles -> ready_in falls 17 edges after the low is first sampled.
- Data freeze: after latching 8'h3C, toggle sw_raw to 8'hFF during LEAD and HELD -> in_port stays 8'h3C until the next accepted press.
- Back-to-back presses with sw_raw = 8'h01 then 8'h02, each press and release held 20 cycles -> two ready_in pulses with in_port=8'h01 and then 8'h02, each stable while ready_in=1.
